// File: rtl/instruction_rom_ctrl.sv
// Fetch-stage instruction memory: registered read, stall hold, safe default for unloaded/out-of-range words.
// Build macro ROM_LOAD_EN enables the load port and clear sweep; otherwise the array is a fixed boot image.
module instruction_rom_ctrl #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'({4'd1, 24'b10101010})
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic                  iReadEnable,
    input  logic                  iStall,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iLoadEnable,
    input  logic [ADDR_WIDTH-1:0] iLoadAddress,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    input  logic                  iClear,
    output logic                  oBusy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  vld_q, vld_d;

    assign rd_in_range = {1'b0, iAddress} < DEPTH_A;

`ifdef ROM_LOAD_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      written_q;
    logic [IDX_W-1:0]      rd_idx, ld_idx;
    logic                  ld_ok;

    assign rd_idx = iAddress[IDX_W-1:0];
    assign ld_idx = iLoadAddress[IDX_W-1:0];
    assign ld_ok  = iLoadEnable && !Reset && (state_q == IDLE) &&
                    ({1'b0, iLoadAddress} < DEPTH_A);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (iClear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (ld_ok) mem_q[ld_idx] <= iLoadData;
    end

    // Reset leaves the image alone: a sweep cut short keeps its uncleared entries.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (state_q == CLEAR) written_q[cnt_q] <= 1'b0;
            else if (ld_ok)       written_q[ld_idx] <= 1'b1;
        end
    end

    assign rd_word = (rd_in_range && (state_q == IDLE) && written_q[rd_idx]) ?
                     mem_q[rd_idx] : DEFAULT_WORD;
    assign oBusy   = (state_q == CLEAR);
`else
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_STO = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [DATA_WIDTH-1:0] BOOT [8] = '{
        DATA_WIDTH'({OP_NOP, 24'd0}),
        DATA_WIDTH'({OP_STO, 8'd1, 16'd16}),
        DATA_WIDTH'({OP_STO, 8'd2, 16'd113}),
        DATA_WIDTH'({OP_ADD, 8'd3, 8'd1, 8'd2}),
        DATA_WIDTH'({OP_SUB, 8'd4, 8'd2, 8'd1}),
        DEFAULT_WORD, DEFAULT_WORD, DEFAULT_WORD
    };

    logic unused_load;
    assign unused_load = ^{iLoadEnable, iLoadAddress, iLoadData, iClear};

    assign rd_word = (rd_in_range && (iAddress < ADDR_WIDTH'(8))) ?
                     BOOT[iAddress[2:0]] : DEFAULT_WORD;
    assign oBusy   = 1'b0;
`endif

    always_comb begin
        inst_d = inst_q;
        vld_d  = vld_q;
        if (!iStall) begin
            vld_d = iReadEnable;
            if (iReadEnable) inst_d = rd_word;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            inst_q <= DEFAULT_WORD;
            vld_q  <= 1'b0;
        end else begin
            inst_q <= inst_d;
            vld_q  <= vld_d;
        end
    end

    assign oInstruction = inst_q;
    assign oValid       = vld_q;
endmodule

// File: tb/tb_instruction_rom_ctrl.sv
// Bench for instruction_rom_ctrl: spec-level model compared every cycle plus literal spot checks.
module tb_instruction_rom_ctrl;
    localparam int         DEPTH = 64;
    localparam logic [27:0] DEF  = 28'h10000AA;

    logic        Clock = 1'b0;
    logic        Reset, iReadEnable, iStall, iLoadEnable, iClear;
    logic [15:0] iAddress, iLoadAddress;
    logic [27:0] iLoadData, oInstruction;
    logic        oValid, oBusy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    instruction_rom_ctrl dut (
        .Clock(Clock), .Reset(Reset), .iAddress(iAddress), .iReadEnable(iReadEnable),
        .iStall(iStall), .oInstruction(oInstruction), .oValid(oValid),
        .iLoadEnable(iLoadEnable), .iLoadAddress(iLoadAddress), .iLoadData(iLoadData),
        .iClear(iClear), .oBusy(oBusy)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Model: memory image, written flags, and how many sweep steps remain.
    logic [27:0] m_mem [DEPTH];
    bit          m_flag [DEPTH];
    int          busy_left = 0;
    logic [27:0] exp_inst = DEF;
    logic        exp_valid = 1'b0;
    logic [27:0] boot [5] = '{28'h0000000, 28'h4010010, 28'h4020071, 28'h5030102, 28'h6040201};

    function automatic logic [27:0] model_word(input logic [15:0] a);
`ifdef ROM_LOAD_EN
        if (a >= DEPTH || busy_left > 0 || !m_flag[a]) return DEF;
        return m_mem[a];
`else
        if (a < 5) return boot[a];
        return DEF;
`endif
    endfunction

    always @(posedge Clock) begin
        logic [27:0] w;
        w = model_word(iAddress);
        if (Reset) begin
            exp_inst  = DEF;
            exp_valid = 1'b0;
            busy_left = 0;
        end else begin
            if (!iStall) begin
                exp_valid = iReadEnable;
                if (iReadEnable) exp_inst = w;
            end
`ifdef ROM_LOAD_EN
            if (busy_left > 0) begin
                m_flag[DEPTH - busy_left] = 0;
                busy_left--;
            end else begin
                if (iLoadEnable && iLoadAddress < DEPTH) begin
                    m_mem[iLoadAddress]  = iLoadData;
                    m_flag[iLoadAddress] = 1;
                end
                if (iClear) busy_left = DEPTH;
            end
`endif
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("model_inst", oInstruction, exp_inst);
            chk("model_valid", oValid, exp_valid);
            chk("model_busy", oBusy, busy_left > 0);
        end
    end

    task automatic cyc(input logic re, input logic [15:0] a, input logic st, input logic le,
                       input logic [15:0] la, input logic [27:0] d, input logic clr);
        iReadEnable = re; iAddress = a; iStall = st;
        iLoadEnable = le; iLoadAddress = la; iLoadData = d; iClear = clr;
        @(posedge Clock);
        #2;
    endtask
    task automatic rd(input logic [15:0] a);                 cyc(1, a, 0, 0, 0, 0, 0); endtask
    task automatic ld(input logic [15:0] a, input logic [27:0] d); cyc(0, 0, 0, 1, a, d, 0); endtask
    task automatic idle();                                   cyc(0, 0, 0, 0, 0, 0, 0); endtask

`ifdef ROM_LOAD_EN
    task automatic sweep(input int drop_at, output int n);
        cyc(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        while (oBusy && n < 200) begin
            if (n == drop_at) ld(7, 28'h7777777);
            else idle();
            n++;
        end
    endtask
`endif

    initial begin
        int n;
        Reset = 1'b1;
        idle();
        idle();
        chk_en = 1;
        chk("reset_inst", oInstruction, DEF);
        chk("reset_valid", oValid, 1'b0);
        chk("reset_busy", oBusy, 1'b0);
        Reset = 1'b0;
`ifdef ROM_LOAD_EN
        sweep(-1, n);
        chk("init_sweep_len", n, 64);
        rd(3);
        chk("rd3_default", oInstruction, DEF);
        chk("rd3_valid", oValid, 1'b1);
        idle();
        chk("noread_valid", oValid, 1'b0);
        chk("noread_hold", oInstruction, DEF);

        ld(5, 28'h1230010);
        rd(5);
        chk("load_then_read", oInstruction, 28'h1230010);
        cyc(1, 5, 0, 1, 5, 28'h0000001, 0);
        chk("read_first", oInstruction, 28'h1230010);
        rd(5);
        chk("new_value", oInstruction, 28'h0000001);

        ld(6, 28'h2220006);
        rd(5);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 6, 1, 0, 0, 0, 0);
            chk("stall_inst", oInstruction, 28'h0000001);
            chk("stall_valid", oValid, 1'b1);
        end
        rd(6);
        chk("after_stall", oInstruction, 28'h2220006);

        for (int i = 0; i < DEPTH; i++) ld(i[15:0], 28'hA000000 + i[27:0]);
        ld(64, 28'hFFFFFFF);
        rd(64);
        chk("oor_read", oInstruction, DEF);
        rd(0);
        chk("oor_load_dropped", oInstruction, 28'hA000000);
        for (int i = 0; i <= DEPTH; i++) rd(i[15:0]);

        sweep(3, n);
        chk("sweep_len", n, 64);
        rd(7);
        chk("sweep_load_dropped", oInstruction, DEF);
        rd(63);
        chk("sweep_cleared_63", oInstruction, DEF);
        for (int i = 0; i < DEPTH; i++) rd(i[15:0]);

        for (int i = 0; i < DEPTH; i++) ld(i[15:0], 28'hB000000 + i[27:0]);
        cyc(0, 0, 0, 0, 0, 0, 1);
        repeat (10) idle();
        Reset = 1'b1;
        idle();
        Reset = 1'b0;
        chk("midreset_busy", oBusy, 1'b0);
        rd(9);
        chk("midreset_cleared_9", oInstruction, DEF);
        rd(10);
        chk("midreset_kept_10", oInstruction, 28'hB00000A);
        for (int i = 0; i < DEPTH; i++) rd(i[15:0]);
        ld(2, 28'h3333333);
        rd(2);
        chk("load_after_sweep", oInstruction, 28'h3333333);
`else
        for (int i = 0; i < 5; i++) begin
            rd(i[15:0]);
            chk("boot_word", oInstruction, boot[i]);
        end
        rd(0);
        chk("boot_nop", oInstruction, 28'h0000000);
        rd(1);
        chk("boot_sto_r1", oInstruction, 28'h4010010);
        rd(3);
        chk("boot_add", oInstruction, 28'h5030102);
        rd(4);
        chk("boot_sub", oInstruction, 28'h6040201);
        idle();
        chk("noread_valid", oValid, 1'b0);
        chk("noread_hold", oInstruction, 28'h6040201);
        ld(0, 28'hFFFFFFF);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("clear_no_busy", oBusy, 1'b0);
        rd(0);
        chk("load_ignored", oInstruction, 28'h0000000);
        rd(1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 2, 1, 0, 0, 0, 0);
            chk("stall_inst", oInstruction, 28'h4010010);
            chk("stall_valid", oValid, 1'b1);
        end
        rd(2);
        chk("after_stall", oInstruction, 28'h4020071);
        rd(5);
        chk("unprogrammed", oInstruction, DEF);
        rd(64);
        chk("oor_read", oInstruction, DEF);
        for (int i = 0; i <= DEPTH; i++) rd(i[15:0]);
`endif
        idle();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
